pc_unit_rs: RTL and testbench

Parametrised next-generation program counter with relative branch, call/return and a hardware return-address stack (RAS).

---
 rtl/pcu_pkg.sv | 12 +
 rtl/pcu_ras.sv | 47 ++++
 rtl/pc_unit_rs.sv | 110 +++++++++++
 tb/tb_pc_unit_rs.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pcu_pkg.sv
// Shared opcode encoding for the program-counter unit.
package pcu_pkg;
  localparam int PCU_OP_W = 3;

  localparam logic [PCU_OP_W-1:0] PCU_HOLD = 3'b000;
  localparam logic [PCU_OP_W-1:0] PCU_INC  = 3'b001;
  localparam logic [PCU_OP_W-1:0] PCU_JMP  = 3'b010;
  localparam logic [PCU_OP_W-1:0] PCU_CLR  = 3'b011;
  localparam logic [PCU_OP_W-1:0] PCU_BRR  = 3'b100;
  localparam logic [PCU_OP_W-1:0] PCU_CALL = 3'b101;
  localparam logic [PCU_OP_W-1:0] PCU_RET  = 3'b110;
endpackage

// File: rtl/pcu_ras.sv
// Return-address stack: LIFO of RAS_DEPTH entries, falling-edge clocked.
// Pushes on full and pops on empty are ignored; the caller flags the fault.
module pcu_ras #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         I_clk,
  input  logic                         I_rst,
  input  logic                         I_push,
  input  logic                         I_pop,
  input  logic                         I_clr,
  input  logic [PC_W-1:0]              I_din,
  output logic [PC_W-1:0]              o_top,
  output logic [$clog2(RAS_DEPTH):0]   o_cnt,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int AW = $clog2(RAS_DEPTH);

  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW-1:0]   wr_idx, top_idx;

  assign wr_idx  = cnt_q[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign o_full  = (cnt_q == (AW+1)'(RAS_DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_top   = mem_q[top_idx];
  assign o_cnt   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (I_clr)                  cnt_d = '0;
    else if (I_push && !o_full) cnt_d = cnt_q + (AW+1)'(1);
    else if (I_pop && !o_empty) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(negedge I_clk or posedge I_rst) begin
    if (I_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Entry storage needs no reset; only entries below the count are ever read.
  always_ff @(negedge I_clk) begin
    if (I_push && !o_full && !I_clr) mem_q[wr_idx] <= I_din;
  end
endmodule

// File: rtl/pc_unit_rs.sv
// Program counter with relative branch, call/return and a return-address stack.
// Optional PCU_TRAP_EN: stack faults redirect the PC to TRAP_VEC.
module pc_unit_rs
  import pcu_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              OFS_W     = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_VEC = 16'h0000,
  parameter logic [PC_W-1:0] TRAP_VEC  = 16'h00F0
) (
  input  logic                        I_clk,
  input  logic                        I_rst,
  input  logic                        I_stall,
  input  logic [PCU_OP_W-1:0]         I_opcode,
  input  logic [PC_W-1:0]             I_pc,
  input  logic [OFS_W-1:0]            I_ofs,
  output logic [PC_W-1:0]             o_pc,
  output logic [$clog2(RAS_DEPTH):0]  o_ras_cnt,
  output logic                        o_ovf,
  output logic                        o_unf
);
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, ofs_ext, ras_top;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            push, pop, clr, ras_full, ras_empty;

  assign pc_inc  = pc_q + PC_W'(1);
  assign ofs_ext = PC_W'($signed(I_ofs));

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    if (!I_stall) begin
      case (I_opcode)
        PCU_INC: pc_d = pc_inc;
        PCU_JMP: pc_d = I_pc;
        PCU_CLR: begin
          pc_d  = RESET_VEC;
          clr   = 1'b1;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        PCU_BRR: pc_d = pc_q + ofs_ext;
        PCU_CALL: begin
          pc_d = I_pc;
          if (ras_full) begin
            ovf_d = 1'b1;
`ifdef PCU_TRAP_EN
            pc_d  = TRAP_VEC;
`endif
          end else begin
            push = 1'b1;
          end
        end
        PCU_RET: begin
          if (ras_empty) begin
            unf_d = 1'b1;
`ifdef PCU_TRAP_EN
            pc_d  = TRAP_VEC;
`else
            pc_d  = pc_inc;
`endif
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pcu_ras #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .I_clk  (I_clk),
    .I_rst  (I_rst),
    .I_push (push),
    .I_pop  (pop),
    .I_clr  (clr),
    .I_din  (pc_inc),
    .o_top  (ras_top),
    .o_cnt  (o_ras_cnt),
    .o_full (ras_full),
    .o_empty(ras_empty)
  );

  assign o_pc  = pc_q;
  assign o_ovf = ovf_q;
  assign o_unf = unf_q;

`ifndef PCU_TRAP_EN
  logic unused_trap;
  assign unused_trap = ^TRAP_VEC;
`endif
endmodule

// File: tb/tb_pc_unit_rs.sv
// Directed bench for pc_unit_rs with a queue-based reference model and scoreboard.
module tb_pc_unit_rs;
  logic        I_clk, I_rst, I_stall;
  logic [2:0]  I_opcode;
  logic [15:0] I_pc;
  logic [7:0]  I_ofs;
  logic [15:0] o_pc;
  logic [2:0]  o_ras_cnt;
  logic        o_ovf, o_unf;

  pc_unit_rs dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_stall(I_stall), .I_opcode(I_opcode),
    .I_pc(I_pc), .I_ofs(I_ofs), .o_pc(o_pc), .o_ras_cnt(o_ras_cnt),
    .o_ovf(o_ovf), .o_unf(o_unf)
  );

  initial I_clk = 1'b1;
  always #5 I_clk = ~I_clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } obs_t;

`ifdef PCU_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  obs_t        sb[$];
  string       tags[$];
  logic [15:0] m_stk[$];
  logic [15:0] m_pc;
  logic        m_ovf, m_unf;
  int          checks = 0;
  int          failures = 0;

  function automatic obs_t model_obs();
    return '{pc: m_pc, cnt: 3'(m_stk.size()), ovf: m_ovf, unf: m_unf};
  endfunction

  function automatic obs_t dut_obs();
    return '{pc: o_pc, cnt: o_ras_cnt, ovf: o_ovf, unf: o_unf};
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_ovf = 1'b0; m_unf = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_apply(input logic stall, input logic [2:0] op,
                             input logic [15:0] pc, input logic [7:0] ofs);
    if (!stall) begin
      case (op)
        3'b001: m_pc = m_pc + 16'd1;
        3'b010: m_pc = pc;
        3'b011: model_reset();
        3'b100: m_pc = m_pc + {{8{ofs[7]}}, ofs};
        3'b101: begin
          if (m_stk.size() == 4) begin
            m_ovf = 1'b1;
            m_pc  = TRAP ? 16'h00F0 : pc;
          end else begin
            m_stk.push_back(m_pc + 16'd1);
            m_pc = pc;
          end
        end
        3'b110: begin
          if (m_stk.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = TRAP ? 16'h00F0 : m_pc + 16'd1;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at the rising edge, record expectation, compare after the falling edge.
  task automatic step(input string tag, input logic stall, input logic [2:0] op,
                      input logic [15:0] pc, input logic [7:0] ofs);
    @(posedge I_clk);
    I_stall = stall; I_opcode = op; I_pc = pc; I_ofs = ofs;
    model_apply(stall, op, pc, ofs);
    sb.push_back(model_obs());
    tags.push_back(tag);
    @(negedge I_clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=output expected=none queued", tag);
    end else begin
      chk(tags.pop_front(), dut_obs(), sb.pop_front());
    end
  endtask

  initial begin
    obs_t snap;
    I_rst = 1'b1; I_stall = 1'b0; I_opcode = 3'b000; I_pc = '0; I_ofs = '0;
    model_reset();
    #3 chk("reset_state", dut_obs(), 22'({16'h0000, 3'd0, 1'b0, 1'b0}));
    @(posedge I_clk); I_rst = 1'b0;

    // Async reset in the middle of a call sequence
    step("pre_call0", 1'b0, 3'b101, 16'h0400, 8'h00);
    step("pre_call1", 1'b0, 3'b101, 16'h0500, 8'h00);
    @(posedge I_clk);
    I_opcode = 3'b101; I_pc = 16'h0600;
    #2 I_rst = 1'b1;
    #1 chk("async_reset", dut_obs(), 22'({16'h0000, 3'd0, 1'b0, 1'b0}));
    model_reset();
    @(negedge I_clk); #1;
    chk("reset_held_edge", dut_obs(), 22'({16'h0000, 3'd0, 1'b0, 1'b0}));
    @(posedge I_clk); I_rst = 1'b0; I_opcode = 3'b000;

    // Wraparound and negative relative branch
    step("jmp_fffe", 1'b0, 3'b010, 16'hFFFE, 8'h00);
    step("inc_ffff", 1'b0, 3'b001, 16'h0000, 8'h00);
    step("inc_wrap", 1'b0, 3'b001, 16'h0000, 8'h00);
    chk("wrap_lit", 22'(o_pc), 22'(16'h0000));
    step("brr_m2", 1'b0, 3'b100, 16'h0000, 8'hFE);
    chk("brr_m2_lit", 22'(o_pc), 22'(16'hFFFE));
    step("brr_p127", 1'b0, 3'b100, 16'h0000, 8'h7F);
    step("brr_m128", 1'b0, 3'b100, 16'h0000, 8'h80);
    step("hold", 1'b0, 3'b000, 16'h1234, 8'h11);
    step("reserved", 1'b0, 3'b111, 16'h1234, 8'h11);

    // Nested call/return
    step("jmp_0010", 1'b0, 3'b010, 16'h0010, 8'h00);
    step("call_0100", 1'b0, 3'b101, 16'h0100, 8'h00);
    step("call_0200", 1'b0, 3'b101, 16'h0200, 8'h00);
    step("ret_0101", 1'b0, 3'b110, 16'h0000, 8'h00);
    chk("ret1_lit", 22'({o_pc, o_ras_cnt}), 22'({16'h0101, 3'd1}));
    step("ret_0011", 1'b0, 3'b110, 16'h0000, 8'h00);
    chk("ret2_lit", 22'({o_pc, o_ras_cnt}), 22'({16'h0011, 3'd0}));

    // Overflow on the fifth call
    for (int i = 0; i < 5; i++)
      step($sformatf("call_%0d", i), 1'b0, 3'b101, 16'h0300 + 16'(i), 8'h00);
    chk("ovf_lit", 22'({o_pc, o_ras_cnt, o_ovf}),
        22'({TRAP ? 16'h00F0 : 16'h0304, 3'd4, 1'b1}));

    // Stall freezes everything regardless of opcode
    snap = dut_obs();
    step("stall_inc", 1'b1, 3'b001, 16'h0000, 8'h00);
    step("stall_call", 1'b1, 3'b101, 16'h0777, 8'h00);
    step("stall_ret", 1'b1, 3'b110, 16'h0000, 8'h00);
    chk("stall_lit", dut_obs(), snap);

    // Pop the full stack back out
    for (int i = 0; i < 4; i++)
      step($sformatf("unwind_%0d", i), 1'b0, 3'b110, 16'h0000, 8'h00);

    // Underflow then CLR
    step("clr0", 1'b0, 3'b011, 16'h0000, 8'h00);
    step("jmp_0020", 1'b0, 3'b010, 16'h0020, 8'h00);
    step("ret_empty", 1'b0, 3'b110, 16'h0000, 8'h00);
    chk("unf_lit", 22'({o_pc, o_ras_cnt, o_unf}),
        22'({TRAP ? 16'h00F0 : 16'h0021, 3'd0, 1'b1}));
    step("unf_sticky", 1'b0, 3'b001, 16'h0000, 8'h00);
    step("clr1", 1'b0, 3'b011, 16'h0000, 8'h00);
    chk("clr_lit", dut_obs(), 22'({16'h0000, 3'd0, 1'b0, 1'b0}));

    if (sb.size() != 0) begin
      checks++; failures++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
